shift_add_multiplier: RTL and testbench

SHIFT_ADD_MULTIPLIER -- requirements
Module: shift_add_multiplier

---
 rtl/shift_add_multiplier.sv | 106 ++++++++++
 tb/tb_shift_add_multiplier.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/shift_add_multiplier.sv
// Sequential shift-add multiplier: retires one multiplier bit per cycle, LSB first.
// Handles signed operands by multiplying magnitudes and negating the product at the end.
module shift_add_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               is_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p,
  output logic               busy
);

  localparam int PW = 2 * WIDTH;
  localparam int SW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic             neg_q, neg_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [PW-1:0]    p_q, p_d;
  logic [SW-1:0]    step_q, step_d;

  logic [WIDTH-1:0] a_mag, b_mag;
  logic [PW-1:0]    addend, sum;

  // Negating the most negative value wraps to 2^(WIDTH-1), which is its correct unsigned magnitude.
  always_comb begin
    a_mag  = (is_signed && a[WIDTH-1]) ? -a : a;
    b_mag  = (is_signed && b[WIDTH-1]) ? -b : b;
    addend = mplier_q[step_q] ? ({{WIDTH{1'b0}}, mcand_q} << step_q) : '0;
    sum    = acc_q + addend;
  end

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    neg_d    = neg_q;
    acc_d    = acc_q;
    p_d      = p_q;
    step_d   = step_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          mcand_d  = a_mag;
          mplier_d = b_mag;
          neg_d    = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
          acc_d    = '0;
          step_d   = '0;
          state_d  = CALC;
        end
      end
      CALC: begin
        acc_d  = sum;
        step_d = step_q + SW'(1);
        if (step_q == SW'(WIDTH - 1)) begin
          // The final partial product is folded in on the same edge that enters DONE.
          p_d     = neg_q ? -sum : sum;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      neg_q    <= 1'b0;
      acc_q    <= '0;
      p_q      <= '0;
      step_q   <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      neg_q    <= neg_d;
      acc_q    <= acc_d;
      p_q      <= p_d;
      step_q   <= step_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign p         = p_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench for shift_add_multiplier (WIDTH=8): scoreboard of expected
// products, handshake timing, backpressure, mid-operation reset and back-to-back accepts.
module tb_shift_add_multiplier;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   a_i;
  logic [W-1:0]   b_i;
  logic           sg;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] p;
  logic           busy;

  int n_checks = 0;
  int n_pass   = 0;
  logic [2*W-1:0] exp_q[$];

  shift_add_multiplier #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a_i),
    .b         (b_i),
    .is_signed (sg),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .p         (p),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Independent reference: plain integer multiply of the interpreted operands.
  function automatic logic [2*W-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic s);
    longint vx, vy, prod;
    vx   = (s && x[W-1]) ? longint'(x) - (longint'(1) << W) : longint'(x);
    vy   = (s && y[W-1]) ? longint'(y) - (longint'(1) << W) : longint'(y);
    prod = vx * vy;
    return prod[2*W-1:0];
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic sb_pop(input string tag, output logic [2*W-1:0] e);
    check({tag, "_pending"}, 32'(exp_q.size() != 0), 32'd1);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
  endtask

  // One full transaction; stall = DONE cycles held with out_ready=0, pulse = poke in_valid meanwhile.
  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                        input int stall, input bit pulse);
    int lat;
    int low;
    int guard;
    logic [2*W-1:0] e;
    out_ready = (stall == 0);
    guard = 0;
    while (!in_ready && guard < 50) begin
      tick();
      guard++;
    end
    check("idle_wait", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    a_i = x;
    b_i = y;
    sg  = s;
    exp_q.push_back(model(x, y, s));
    low = 0;
    tick();
    in_valid = 1'b0;
    a_i = ~x;
    b_i = W'($urandom);
    sg  = ~s;
    check("accept_busy", 32'(busy), 32'd1);
    if (!in_ready) low++;
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
      if (!in_ready) low++;
    end
    check("latency", 32'(lat), 32'(W));
    sb_pop("result", e);
    check("p", 32'(p), 32'(e));
    for (int i = 0; i < stall; i++) begin
      if (pulse) begin
        in_valid = 1'b1;
        a_i = W'($urandom);
        b_i = W'($urandom);
      end
      tick();
      if (!in_ready) low++;
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_p", 32'(p), 32'(e));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check("post_in_ready", 32'(in_ready), 32'd1);
    check("post_out_valid", 32'(out_valid), 32'd0);
    check("p_retain", 32'(p), 32'(e));
    check("in_ready_low", 32'(low), 32'(W + 1 + stall));
  endtask

  initial begin
    int acc_cyc[2];
    int n_acc;
    int n_res;
    int cyc;
    logic [2*W-1:0] e;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a_i = '0;
    b_i = '0;
    sg  = 1'b0;
    #3;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_p", 32'(p), 32'd0);
    tick();
    rst_n = 1'b1;

    run_op(8'd15, 8'd15, 1'b0, 0, 1'b0);
    run_op(8'd255, 8'd255, 1'b0, 0, 1'b0);
    run_op(8'h80, 8'h80, 1'b1, 0, 1'b0);
    run_op(8'hFF, 8'd5, 1'b1, 0, 1'b0);
    run_op(8'h80, 8'd127, 1'b1, 0, 1'b0);
    run_op(8'd0, 8'd77, 1'b0, 0, 1'b0);
    run_op(8'd3, 8'd7, 1'b0, 5, 1'b1);
    for (int i = 0; i < 4; i++)
      run_op(W'($urandom), W'($urandom), 1'($urandom), 0, 1'b0);

    // Abort mid-calculation: the aborted result must never surface.
    in_valid = 1'b1;
    a_i = 8'd200;
    b_i = 8'd100;
    sg  = 1'b0;
    exp_q.push_back(model(8'd200, 8'd100, 1'b0));
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("mid_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_p", 32'(p), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    tick();
    rst_n = 1'b1;
    run_op(8'd2, 8'd3, 1'b0, 0, 1'b0);

    // Back-to-back: in_valid stays high across two operand pairs.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    a_i = 8'd11;
    b_i = 8'd13;
    sg  = 1'b0;
    acc_cyc[0] = 0;
    acc_cyc[1] = 0;
    n_acc = 0;
    n_res = 0;
    cyc   = 0;
    while (n_res < 2 && cyc < 60) begin
      if (out_valid) begin
        sb_pop("b2b_result", e);
        check("b2b_p", 32'(p), 32'(e));
        n_res++;
      end
      if (in_ready && in_valid && n_acc < 2) begin
        acc_cyc[n_acc] = cyc;
        exp_q.push_back(model(a_i, b_i, sg));
        n_acc++;
      end
      tick();
      cyc++;
      if (n_acc == 1) begin
        a_i = 8'd250;
        b_i = 8'd9;
      end else if (n_acc == 2) begin
        in_valid = 1'b0;
      end
    end
    check("b2b_results", 32'(n_res), 32'd2);
    check("b2b_spacing", 32'(acc_cyc[1] - acc_cyc[0]), 32'd10);
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
